stopwatch_core: RTL

Seconds stopwatch feeding the two-digit seven-segment display path: it debounces two raw push-buttons, runs a start/pause/clear state machine and a 1 Hz BCD count of 00–59. Its `tens` and `ones` digits drive the downstream digit selector, which the scan and segment-decoder stages then multiplex onto `ds[1]` and `ds[0]`. It runs on the board 50 MHz clock, so no separate divided clock is needed.

---
 rtl/stopwatch_core.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/stopwatch_core.sv
// Seconds stopwatch core: two conditioned push-buttons drive a start/pause/clear
// state machine that gates a prescaler and a 00-59 BCD seconds counter. The
// tens/ones digits feed the two-digit seven-segment scan path downstream.

// Button conditioner: 2-flop synchronizer, counter debouncer, rising-edge pulse.
module btn_conditioner #(
    parameter int DB_CYCLES = 500_000
) (
    input  logic clk_50mhz,
    input  logic rst,
    input  logic btn,
    output logic press
);
    localparam int DB_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

    logic            sync_q1;
    logic            sync_q2;
    logic            stable;
    logic            stable_q;
    logic [DB_W-1:0] db_cnt;

    // Bring the raw, asynchronous button level into the clock domain
    always_ff @(posedge clk_50mhz or posedge rst) begin
        if (rst) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= btn;
            sync_q2 <= sync_q1;
        end
    end

    // Accept a new level only after DB_CYCLES consecutive differing samples
    always_ff @(posedge clk_50mhz or posedge rst) begin
        if (rst) begin
            stable <= 1'b0;
            db_cnt <= '0;
        end else if (sync_q2 == stable) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
            stable <= ~stable;
            db_cnt <= '0;
        end else begin
            db_cnt <= db_cnt + DB_W'(1);
        end
    end

    // Delayed copy of the debounced level for press detection
    always_ff @(posedge clk_50mhz or posedge rst) begin
        if (rst) begin
            stable_q <= 1'b0;
        end else begin
            stable_q <= stable;
        end
    end

    // Releases are deliberately ignored; only a 0->1 of the stable level counts
    assign press = stable & ~stable_q;

endmodule

// State   | Meaning
// --------+-----------------------------------------------------------
// IDLE    | reset/cleared; digits 00, prescaler held at 0
// RUN     | prescaler counting, digits advance once per TICK_DIV cycles
// PAUSE   | prescaler and digits frozen; fractional second retained
module stopwatch_core #(
    parameter int TICK_DIV  = 50_000_000,
    parameter int DB_CYCLES = 500_000
) (
    input  logic       clk_50mhz,
    input  logic       rst,
    input  logic       btn_ss,
    input  logic       btn_clr,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       running,
    output logic       wrap
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;

    localparam int PS_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);

    logic [1:0]      state;
    logic [1:0]      state_nxt;
    logic [PS_W-1:0] presc;
    logic            ss_p;
    logic            clr_p;
    logic            tick;

    btn_conditioner #(.DB_CYCLES(DB_CYCLES)) u_cond_ss (
        .clk_50mhz (clk_50mhz),
        .rst       (rst),
        .btn       (btn_ss),
        .press     (ss_p)
    );

    btn_conditioner #(.DB_CYCLES(DB_CYCLES)) u_cond_clr (
        .clk_50mhz (clk_50mhz),
        .rst       (rst),
        .btn       (btn_clr),
        .press     (clr_p)
    );

    assign tick = (state == ST_RUN) && (presc == PS_LAST);

    // Next state: clear overrides start/stop from every state
    always_comb begin
        state_nxt = state;
        if (clr_p) begin
            state_nxt = ST_IDLE;
        end else if (ss_p) begin
            case (state)
                ST_IDLE:  state_nxt = ST_RUN;
                ST_RUN:   state_nxt = ST_PAUSE;
                ST_PAUSE: state_nxt = ST_RUN;
                default:  state_nxt = ST_IDLE;
            endcase
        end else if ((state != ST_IDLE) && (state != ST_RUN) && (state != ST_PAUSE)) begin
            state_nxt = ST_IDLE;
        end
    end

    // State register; running is registered from the next state so it is glitch-free
    always_ff @(posedge clk_50mhz or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            running <= 1'b0;
        end else begin
            state   <= state_nxt;
            running <= (state_nxt == ST_RUN);
        end
    end

    // Prescaler: counts only in RUN, holds in PAUSE, parked at 0 in IDLE
    always_ff @(posedge clk_50mhz or posedge rst) begin
        if (rst) begin
            presc <= '0;
        end else if (clr_p || tick) begin
            presc <= '0;
        end else if (state == ST_RUN) begin
            presc <= presc + PS_W'(1);
        end else if (state == ST_IDLE) begin
            presc <= '0;
        end
    end

    // BCD seconds count with a one-cycle pulse aligned to the first 00 after 59
    always_ff @(posedge clk_50mhz or posedge rst) begin
        if (rst) begin
            tens <= 4'd0;
            ones <= 4'd0;
            wrap <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (clr_p) begin
                tens <= 4'd0;
                ones <= 4'd0;
            end else if (tick) begin
                if (ones < 4'd9) begin
                    ones <= ones + 4'd1;
                end else begin
                    ones <= 4'd0;
                    if (tens < 4'd5) begin
                        tens <= tens + 4'd1;
                    end else begin
                        tens <= 4'd0;
                        wrap <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
